// File: rtl/serial_config_receiver.sv
// Receiver for the four-wire configuration link: synchronizes and glitch-filters
// the wires, shifts in an MSB-first frame and captures it on the scapt strobe.
module serial_config_receiver #(
  parameter int              NBITS     = 96,
  parameter int              FILT_LEN  = 2,
  parameter bit              INPUT_INV = 1'b1,
  parameter logic [NBITS-1:0] CFG_RESET = '0
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             s_sck,
  input  logic             s_sda,
  input  logic             s_scapt,
  input  logic             s_reset,
  output logic [NBITS-1:0] cfg_q,
  output logic             cfg_valid,
  output logic             len_err,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       bit_cnt
);

  localparam logic [3:0] FL       = 4'(FILT_LEN);
  localparam logic [7:0] CNT_FULL = 8'(NBITS);
  localparam logic [7:0] CNT_MAX  = 8'(NBITS + 1);

  // Wire order in the conditioning vectors: {reset, scapt, sda, sck}
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       filt;
  logic [3:0]       fcnt [4];
  logic             sck_d;
  logic             scapt_d;
  logic             sck_rise;
  logic             scapt_rise;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] n_shreg;
  logic [7:0]       n_cnt;

  assign raw        = {s_reset, s_scapt, s_sda, s_sck} ^ {4{INPUT_INV}};
  assign sck_rise   = filt[0] & ~sck_d;
  assign scapt_rise = filt[2] & ~scapt_d;
  assign busy       = (bit_cnt != '0);

  // Shift result is computed first so a coincident capture sees post-shift state
  always_comb begin
    n_shreg = shreg;
    n_cnt   = bit_cnt;
    if (sck_rise) begin
      n_shreg = {shreg[NBITS-2:0], filt[1]};
      if (bit_cnt != CNT_MAX) n_cnt = bit_cnt + 8'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      filt      <= '0;
      for (int unsigned i = 0; i < 4; i++) fcnt[i] <= '0;
      sck_d     <= 1'b0;
      scapt_d   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      cfg_q     <= CFG_RESET;
      cfg_valid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      sck_d   <= filt[0];
      scapt_d <= filt[2];
      // Level flips only after FILT_LEN consecutive disagreeing samples
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FL - 4'd1) begin
            filt[i] <= ~filt[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 4'd1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end

      cfg_valid <= 1'b0;
      len_err   <= 1'b0;
      if (filt[3]) begin
        shreg   <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
        cfg_q   <= CFG_RESET;
      end else begin
        shreg   <= n_shreg;
        bit_cnt <= n_cnt;
        if (sck_rise && n_cnt == CNT_MAX) overrun <= 1'b1;
        if (scapt_rise) begin
          if (n_cnt == CNT_FULL) begin
            cfg_q     <= n_shreg;
            cfg_valid <= 1'b1;
          end else begin
            len_err   <= 1'b1;
          end
          bit_cnt <= '0;
          overrun <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_config_receiver.sv
// Directed bench for serial_config_receiver; wires are driven inverted to match INPUT_INV=1.
module tb_serial_config_receiver;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0, sda = 1'b0, scapt = 1'b0, lrst = 1'b0;
  logic [95:0] cfg_q;
  logic        cfg_valid, len_err, busy, overrun;
  logic [7:0]  bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] pat_a, pat_b, pat_c;

  always #5 clkin = ~clkin;

  serial_config_receiver #(
    .NBITS(96),
    .FILT_LEN(2),
    .INPUT_INV(1'b1),
    .CFG_RESET(96'h0)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .s_sck(~sck),
    .s_sda(~sda),
    .s_scapt(~scapt),
    .s_reset(~lrst),
    .cfg_q(cfg_q),
    .cfg_valid(cfg_valid),
    .len_err(len_err),
    .busy(busy),
    .overrun(overrun),
    .bit_cnt(bit_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    cycles(8);
    sck = 1'b1;
    cycles(8);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [95:0] p, input int n);
    for (int i = 95; i > 95 - n; i--) send_bit(p[i]);
  endtask

  // Raise scapt (optionally with sck) and watch the output pulses for 12 cycles
  task automatic capture(input string tag, input bit with_sck, input bit exp_valid, input bit exp_err);
    int vcnt = 0, vfirst = 0, ecnt = 0, efirst = 0, both = 0;
    scapt = 1'b1;
    if (with_sck) sck = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clkin);
      if (cfg_valid === 1'b1) begin
        vcnt++;
        if (vfirst == 0) vfirst = i;
      end
      if (len_err === 1'b1) begin
        ecnt++;
        if (efirst == 0) efirst = i;
      end
      if (cfg_valid === 1'b1 && len_err === 1'b1) both++;
      if (i == 5) begin
        scapt = 1'b0;
        sck   = 1'b0;
      end
    end
    check({tag, "_valid_cnt"}, vcnt, exp_valid ? 1 : 0);
    check({tag, "_valid_at"},  vfirst, exp_valid ? 5 : 0);
    check({tag, "_err_cnt"},   ecnt, exp_err ? 1 : 0);
    check({tag, "_err_at"},    efirst, exp_err ? 5 : 0);
    check({tag, "_both"},      both, 0);
  endtask

  initial begin
    pat_a = 96'hFE80_0700_F803_C001_800F_800C;
    pat_b = 96'h0123_4567_89AB_CDEF_FEDC_BA99;
    pat_c = 96'h5A5A_0F0F_C3C3_9696_1234_8765;

    cycles(2);
    rst = 1'b0;
    cycles(1);
    check("rst_cfg_q", cfg_q, 96'h0);
    check("rst_valid", cfg_valid, 0);
    check("rst_err", len_err, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bit_cnt", bit_cnt, 0);

    // Nominal frame
    send_bits(pat_a, 96);
    check("nom_cnt96", bit_cnt, 96);
    check("nom_busy", busy, 1);
    check("nom_overrun", overrun, 0);
    capture("nom", 1'b0, 1'b1, 1'b0);
    check("nom_cfg_q", cfg_q, pat_a);
    check("nom_cnt0", bit_cnt, 0);
    check("nom_idle", busy, 0);

    // Short frame
    send_bits(~pat_a, 95);
    check("short_cnt", bit_cnt, 95);
    capture("short", 1'b0, 1'b0, 1'b1);
    check("short_cfg_q", cfg_q, pat_a);
    check("short_busy", busy, 0);

    // Long frame
    send_bits(pat_b, 96);
    check("long_ovr96", overrun, 0);
    send_bit(1'b1);
    check("long_ovr97", overrun, 1);
    check("long_cnt97", bit_cnt, 97);
    send_bit(1'b0);
    check("long_sat", bit_cnt, 97);
    capture("long", 1'b0, 1'b0, 1'b1);
    check("long_ovr_clr", overrun, 0);
    check("long_cnt0", bit_cnt, 0);
    check("long_cfg_q", cfg_q, pat_a);

    // Glitch rejection
    sda = 1'b1;
    cycles(8);
    sck = 1'b1;
    cycles(1);
    sck = 1'b0;
    cycles(10);
    check("glitch_sck", bit_cnt, 0);
    scapt = 1'b1;
    cycles(1);
    scapt = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clkin);
        if (cfg_valid === 1'b1 || len_err === 1'b1) pulses++;
      end
      check("glitch_scapt", pulses, 0);
    end
    sck = 1'b1;
    cycles(3);
    sck = 1'b0;
    cycles(10);
    check("pulse3_cnt", bit_cnt, 1);
    capture("pulse3", 1'b0, 1'b0, 1'b1);

    // Link reset mid-frame
    send_bits(pat_b, 40);
    check("lrst_pre_cnt", bit_cnt, 40);
    lrst = 1'b1;
    cycles(10);
    check("lrst_cfg_q", cfg_q, 96'h0);
    check("lrst_cnt", bit_cnt, 0);
    check("lrst_busy", busy, 0);
    lrst = 1'b0;
    cycles(10);
    send_bits(pat_c, 96);
    capture("after_lrst", 1'b0, 1'b1, 1'b0);
    check("after_lrst_cfg_q", cfg_q, pat_c);

    // Simultaneous sck and scapt after 95 bits
    send_bits(pat_b, 95);
    sda = pat_b[0];
    cycles(8);
    capture("simul", 1'b1, 1'b1, 1'b0);
    check("simul_cfg_q", cfg_q, pat_b);
    check("simul_bit0", cfg_q[0], 1'b1);
    check("simul_cnt", bit_cnt, 0);

    // rst during a shift
    send_bits(pat_a, 20);
    check("mid_cnt", bit_cnt, 20);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_cnt", bit_cnt, 0);
    check("mid_rst_cfg_q", cfg_q, 96'h0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_config_receiver.md
# serial_config_receiver

Chip-side receiver for the four-wire configuration link (sck, sda, scapt, reset) driven by the board programmer. It oversamples the wires on the local `clkin`, filters glitches, shifts in the MSB-first bit stream and, on a capture strobe, transfers a complete frame into a parallel configuration register. It sits between the programmer's output pads and the TDC configuration bits, and is the counterpart of the serializer that loads registers 2..13.

## Interface

Parameters:
- `NBITS`, 96: frame length in bits (registers 2..13, 8 bits each).
- `FILT_LEN`, 2: consecutive equal samples required before a filtered wire changes level; legal range 1..15.
- `INPUT_INV`, 1: 1 means all four wires arrive inverted and are re-inverted inside the block; 0 means they arrive active-high.
- `CFG_RESET`, 96'h0: value loaded into `cfg_q` by either reset.

Ports:
- `clkin`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high block reset.
- `s_sck`, input, 1: serial clock wire; asynchronous to `clkin`.
- `s_sda`, input, 1: serial data wire; asynchronous.
- `s_scapt`, input, 1: capture strobe wire; asynchronous.
- `s_reset`, input, 1: link reset wire; asynchronous.
- `cfg_q`, output, NBITS: captured configuration. Bit NBITS-1 is the first bit received.
- `cfg_valid`, output, 1: one-cycle pulse when `cfg_q` is updated.
- `len_err`, output, 1: one-cycle pulse when a capture is rejected because of a wrong bit count.
- `busy`, output, 1: high while a frame is partially shifted (bit count ≠ 0).
- `overrun`, output, 1: sticky flag, set when more than NBITS bits are received.
- `bit_cnt`, output, 8: number of bits received in the current frame, saturating at NBITS+1.

## Operation

- **Input conditioning.** Each wire is optionally inverted (`INPUT_INV`), then passed through a 2-flop synchronizer, then a per-wire filter.
  - The filter keeps a count of consecutive samples that differ from the current filtered level.
  - When that count reaches `FILT_LEN`, the filtered level flips.
  - A level held for fewer than `FILT_LEN` samples is discarded.
- **Edge detection.** The block registers the filtered sck and scapt and detects their rising edges. Reset on the link is level-sensitive on the filtered `s_reset`.
- **States.**
  - IDLE: `bit_cnt` = 0.
  - SHIFT: 0 < `bit_cnt` ≤ NBITS.
  - OVER: `bit_cnt` = NBITS+1.
- **sck rising edge.**
  - `shreg` becomes {`shreg`[NBITS-2:0], filtered sda}.
  - `bit_cnt` increments, saturating at NBITS+1.
  - The transition into OVER sets `overrun`.
- **scapt rising edge.**
  - If `bit_cnt` = NBITS: load `cfg_q` from `shreg`, pulse `cfg_valid`.
  - Otherwise: pulse `len_err` and leave `cfg_q` unchanged.
  - In both cases `bit_cnt` returns to 0 (IDLE) and `overrun` clears.
  - A scapt edge in IDLE (zero bits received) also pulses `len_err`.
- **sck and scapt rising edges in the same cycle.** The shift is applied first. Capture evaluates the post-shift `bit_cnt` and `shreg`.
- **Filtered `s_reset` high.**
  - Actions: `shreg` = 0, `bit_cnt` = 0, `overrun` = 0, `cfg_q` = `CFG_RESET`.
  - sck and scapt edges are ignored while it stays high.
  - No pulse is generated.
  - A frame that was partially shifted is lost.
- **`rst` high.**
  - Resets everything `s_reset` resets.
  - Additionally resets the synchronizers, filters (filtered level = 0, filter counts = 0) and edge registers.
  - Takes priority over everything else.
- **Data hold.** `cfg_q` holds its value indefinitely between captures; it is never partially updated.

## Timing

- Reset values:
  - `cfg_q` = `CFG_RESET`.
  - `cfg_valid`, `len_err`, `busy`, `overrun` = 0.
  - `bit_cnt` = 0.
- Latency from the first `clkin` edge that samples a new wire level to the cycle in which the registered outputs reflect it:
  - 2 cycles for the synchronizer,
  - `FILT_LEN` cycles for the filter,
  - 1 cycle for edge detect and output update,
  - total `FILT_LEN`+3 cycles (5 at default).
- Wire timing requirements:
  - sck high and low phases ≥ `FILT_LEN`+1 `clkin` periods each.
  - sda stable ≥ `FILT_LEN`+2 periods before and after the sck rising edge.
  - scapt pulse ≥ `FILT_LEN`+1 periods.
- `cfg_valid` and `len_err` are exactly 1 cycle wide and are never high in the same cycle.
- `busy`, `overrun` and `bit_cnt` update in the same cycle as the `cfg_q`/pulse outputs.

## Test plan

- **Nominal frame.** `rst` 2 cycles, then shift 96 bits of 96'hFE80_0700_F803_C001_800F_800C MSB-first with sck period 16 `clkin`, then a scapt pulse.
  - `cfg_q` equals the pattern.
  - `cfg_valid` is exactly 1 cycle wide, 5 cycles after the sampled scapt edge.
  - `bit_cnt` reads 96 then 0.
- **Short frame.** Shift 95 bits, then scapt.
  - `len_err` pulses for 1 cycle.
  - `cfg_q` keeps its previous value.
  - `busy` drops.
- **Long frame.** Shift 97 bits.
  - `overrun` rises on the 97th edge.
  - `bit_cnt` saturates at 97.
  - The following scapt gives `len_err`, and `overrun` clears.
- **Glitch rejection.** 1-cycle pulses on sck and scapt with `FILT_LEN`=2: no shift, no capture, `bit_cnt` unchanged. A 3-cycle sck pulse shifts exactly 1 bit.
- **Link reset mid-frame.** Assert `s_reset` after 40 bits.
  - `cfg_q` = `CFG_RESET`, `bit_cnt` = 0.
  - A subsequent full 96-bit frame captures correctly.
- **Simultaneous edges.** Drive sck and scapt rising on the same sample after 95 bits.
  - `cfg_valid` pulses.
  - `cfg_q`[0] equals the last sda bit.
  - `rst` asserted during a shift clears all state on the next edge.
